// File: rtl/fifo_feed_ctrl.sv
// rtl/fifo_feed_ctrl.sv - sequencer for a bank of fifo delay buffers feeding a systolic array
module fifo_feed_ctrl #(
  parameter  int DIM   = 8,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DIM + DEPTH) + 1,
  localparam int IW    = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  output logic          fifo_en,
  output logic          zero_fill,
  output logic [IW-1:0] in_idx,
  output logic          out_valid,
  output logic [IW-1:0] out_idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] c_q;
  logic [CW-1:0] c_d;
  logic          busy_q;
  logic          done_q;
  logic          shifting;

  assign shifting  = (state_q == FILL) || (state_q == DRAIN);
  assign fifo_en   = shifting && !stall;
  assign zero_fill = (state_q == DRAIN);
  assign in_idx    = (state_q == FILL) ? c_q[IW-1:0] : '0;
  assign c_d       = c_q + CW'(1);

  // c_q counts completed shifts, so column j sits on q once DEPTH+j shifts have happened.
  assign out_valid = (state_q != IDLE) && (c_q >= CW'(DEPTH)) && (c_q <= CW'(DEPTH + DIM - 1));
  assign out_idx   = out_valid ? IW'(c_q - CW'(DEPTH)) : '0;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FILL;
            busy_q  <= 1'b1;
          end
        end
        FILL: begin
          if (!stall) begin
            c_q <= c_d;
            if (c_q == CW'(DIM - 1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!stall) begin
            c_q <= c_d;
            if (c_q == CW'(DIM + DEPTH - 2)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          c_q     <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          c_q     <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
